// File: rtl/pc_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_unit: program counter with prioritised next-PC select, RAS and EPC.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0080,
  parameter int unsigned INC        = 4,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic             call,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             ret,
  input  logic             trap,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] TRAP_ADDR = WIDTH'(TRAP_VEC);
  localparam logic [WIDTH-1:0] STEP      = WIDTH'(INC);
  localparam logic [PW:0]      FULL_CNT  = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_inc;
  logic [PW:0]      count;
  logic [WIDTH-1:0] ras_top;

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] epc_next;
  logic             err_next;
  logic             push;
  logic             pop;
  logic             swap;

  assign pc_plus   = pc + STEP;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL_CNT);
  assign top_inc   = top + PW'(1);
  assign ras_top   = ras_mem[top];

  always_comb begin
    pc_next  = pc_plus;
    epc_next = epc;
    err_next = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    swap     = 1'b0;
    if (trap) begin
      pc_next  = TRAP_ADDR;
      epc_next = pc;
    end else if (stall) begin
      pc_next = pc;
    end else if (eret) begin
      pc_next = epc;
    end else if (ret && ras_empty) begin
      // Underflowing return is promoted to a trap so software can recover.
      pc_next  = TRAP_ADDR;
      epc_next = pc;
      err_next = 1'b1;
    end else if (ret && call) begin
      pc_next = ras_top;
      swap    = 1'b1;
    end else if (ret) begin
      pc_next = ras_top;
      pop     = 1'b1;
    end else if (call) begin
      pc_next = jmp_target;
      push    = 1'b1;
    end else if (jmp) begin
      pc_next = jmp_target;
    end else if (br_taken) begin
      pc_next = br_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_ADDR;
      epc     <= '0;
      ras_err <= 1'b0;
      top     <= '0;
      count   <= '0;
    end else begin
      pc      <= pc_next;
      epc     <= epc_next;
      ras_err <= err_next;
      if (push) begin
        top <= top_inc;
        if (!ras_full) count <= count + 1'b1;
      end else if (pop) begin
        top   <= top - PW'(1);
        count <= count - 1'b1;
      end
    end
  end

  // Entry storage carries no reset; a full push overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (push)      ras_mem[top_inc] <= pc_plus;
    else if (swap) ras_mem[top]     <= pc_plus;
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// Directed scoreboard bench for pc_unit (WIDTH=32, RAS_DEPTH=4).
module tb_pc_unit;

  logic        clk, rst, stall, br_taken, jmp, call, ret, trap, eret;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc, pc_plus, epc;
  logic        ras_empty, ras_full, ras_err;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .call(call), .jmp_target(jmp_target), .ret(ret), .trap(trap), .eret(eret),
    .pc(pc), .pc_plus(pc_plus), .epc(epc),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  localparam int S_PC = 0, S_EPC = 1, S_PLUS = 2, S_EMPTY = 3, S_FULL = 4, S_ERR = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_PC:    return pc;
      S_EPC:   return epc;
      S_PLUS:  return pc_plus;
      S_EMPTY: return {31'd0, ras_empty};
      S_FULL:  return {31'd0, ras_full};
      default: return {31'd0, ras_err};
    endcase
  endfunction

  task automatic expect_v(string tag, int sel, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic clr();
    stall = 0; br_taken = 0; br_target = '0; jmp = 0; call = 0;
    jmp_target = '0; ret = 0; trap = 0; eret = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
    check_sb();
  endtask

  task automatic go_to(logic [31:0] a);
    jmp = 1; jmp_target = a;
    expect_v("jmp_setup", S_PC, a);
    tick();
  endtask

  task automatic do_call(logic [31:0] t, string tag);
    call = 1; jmp_target = t;
    expect_v(tag, S_PC, t);
    tick();
  endtask

  task automatic do_ret(logic [31:0] exp_pc, string tag);
    ret = 1;
    expect_v(tag, S_PC, exp_pc);
    tick();
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    expect_v("seq_pre_a", S_PC, 32'h4); tick();
    expect_v("seq_pre_b", S_PC, 32'h8); tick();

    // 1. async reset mid-cycle, then sequential stepping
    #2 rst = 1;
    #1;
    expect_v("rst_pc", S_PC, 32'h0);
    expect_v("rst_epc", S_EPC, 32'h0);
    expect_v("rst_plus", S_PLUS, 32'h4);
    expect_v("rst_empty", S_EMPTY, 1);
    expect_v("rst_full", S_FULL, 0);
    expect_v("rst_err", S_ERR, 0);
    check_sb();
    #1 rst = 0;
    expect_v("seq_4", S_PC, 32'h4);  tick();
    expect_v("seq_8", S_PC, 32'h8);  tick();
    expect_v("seq_c", S_PC, 32'hC);
    expect_v("seq_plus", S_PLUS, 32'h10); tick();

    // 2. priority and stall
    br_taken = 1; br_target = 32'h100; jmp = 1; jmp_target = 32'h200;
    expect_v("jmp_over_br", S_PC, 32'h200); tick();
    stall = 1; br_taken = 1; br_target = 32'h100;
    expect_v("stall_hold", S_PC, 32'h200); tick();
    stall = 1; eret = 1;
    expect_v("stall_eret", S_PC, 32'h200); tick();
    stall = 1; trap = 1;
    expect_v("stall_trap_pc", S_PC, 32'h80);
    expect_v("stall_trap_epc", S_EPC, 32'h200);
    expect_v("stall_trap_err", S_ERR, 0); tick();

    // 3. call / return
    go_to(32'h10);
    do_call(32'h400, "call1");
    expect_v("call1_nonempty", S_EMPTY, 0); check_sb();
    do_call(32'h800, "call2");
    stall = 1; ret = 1;
    expect_v("stall_ret", S_PC, 32'h800); tick();
    do_ret(32'h404, "ret1");
    do_ret(32'h14, "ret2");
    expect_v("ret2_empty", S_EMPTY, 1); check_sb();

    // 4. overflow and underflow
    go_to(32'h0);
    for (int i = 0; i < 5; i++) do_call(32'(i + 1) * 32'h100, "ovf_call");
    expect_v("ovf_full", S_FULL, 1);
    expect_v("ovf_empty", S_EMPTY, 0); check_sb();
    do_ret(32'h404, "uf_ret1");
    expect_v("uf_notfull", S_FULL, 0); check_sb();
    do_ret(32'h304, "uf_ret2");
    do_ret(32'h204, "uf_ret3");
    do_ret(32'h104, "uf_ret4");
    expect_v("uf_empty", S_EMPTY, 1); check_sb();
    ret = 1;
    expect_v("uf_pc", S_PC, 32'h80);
    expect_v("uf_epc", S_EPC, 32'h104);
    expect_v("uf_err", S_ERR, 1); tick();
    expect_v("uf_err_clr", S_ERR, 0);
    expect_v("uf_next", S_PC, 32'h84); tick();

    // 5. trap / eret
    go_to(32'h3C);
    trap = 1;
    expect_v("trap_pc", S_PC, 32'h80);
    expect_v("trap_epc", S_EPC, 32'h3C); tick();
    expect_v("hnd_84", S_PC, 32'h84); tick();
    expect_v("hnd_88", S_PC, 32'h88); tick();
    eret = 1; ret = 1; call = 1; jmp_target = 32'h999;
    expect_v("eret_pc", S_PC, 32'h3C);
    expect_v("eret_keep_empty", S_EMPTY, 1); tick();

    // 6. wrap and simultaneous call+ret
    go_to(32'hFFFF_FFFC);
    expect_v("wrap_plus", S_PLUS, 32'h0); check_sb();
    expect_v("wrap_pc", S_PC, 32'h0); tick();
    go_to(32'h20);
    do_call(32'h50, "cr_setup");
    call = 1; ret = 1; jmp_target = 32'h700;
    expect_v("cr_pc", S_PC, 32'h24);
    expect_v("cr_nonempty", S_EMPTY, 0);
    expect_v("cr_notfull", S_FULL, 0); tick();
    do_ret(32'h54, "cr_top");
    expect_v("cr_count1", S_EMPTY, 1); check_sb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
